// File: rtl/sb_rx_pattern_detector.sv
// rtl/sb_rx_pattern_detector.sv - sideband RX clock-pattern detector with timeout
//
// Purpose: watches deserialized 64-bit sideband words during sideband init and
// reports when REQ_MATCHES consecutive clock-pattern words (either UI alignment)
// have been seen, or flags a timeout if the detection window expires first.
//
// Ports:
//   i_clk                      block clock
//   i_rst_n                    asynchronous active-low reset
//   i_start_detect_req         LTSM level request; detection runs while high
//   i_deser_data[63:0]         deserialized sideband word
//   i_deser_valid              i_deser_data valid this cycle
//   o_rx_sb_pattern_samp_done  one-cycle pulse on detection (to TX pattern gen)
//   o_pattern_detected         level, detection achieved (to LTSM)
//   o_detect_time_out          level, window expired without detection (to LTSM)
//   o_match_cnt[2:0]           current consecutive-match count

module sb_rx_pattern_detector #(
    parameter logic [63:0] PATTERN       = {32{2'b10}},
    parameter int          REQ_MATCHES   = 2,
    parameter int          CYCLES_PER_MS = 100,
    parameter int          TIMEOUT_MS    = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start_detect_req,
    input  logic [63:0] i_deser_data,
    input  logic        i_deser_valid,
    output logic        o_rx_sb_pattern_samp_done,
    output logic        o_pattern_detected,
    output logic        o_detect_time_out,
    output logic [2:0]  o_match_cnt
);

    localparam int              TOTAL      = CYCLES_PER_MS * TIMEOUT_MS;
    localparam int              TW         = $clog2(TOTAL);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TOTAL - 1);
    localparam logic [2:0]      REQ_CNT    = 3'(REQ_MATCHES);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SEARCH   = 2'd1;
    localparam logic [1:0] ST_DETECTED = 2'd2;
    localparam logic [1:0] ST_TIMEOUT  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          pol_q, pol_d;        // 0: nominal alignment, 1: 1-UI shifted
    logic          samp_done_q, samp_done_d;

    logic is_a;
    logic is_b;
    logic is_match;

    assign is_a     = (i_deser_data == PATTERN);
    assign is_b     = (i_deser_data == ~PATTERN);
    assign is_match = is_a | is_b;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        cnt_d       = cnt_q;
        pol_d       = pol_q;
        samp_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                cnt_d   = '0;
                pol_d   = 1'b0;
                if (i_start_detect_req) begin
                    state_d = ST_SEARCH;
                end
            end

            ST_SEARCH: begin
                if (!i_start_detect_req) begin
                    // Abandoned search: no pulse, no timeout.
                    state_d = ST_IDLE;
                    timer_d = '0;
                    cnt_d   = '0;
                    pol_d   = 1'b0;
                end else begin
                    timer_d = timer_q + 1'b1;
                    // Invalid cycles leave count and alignment untouched, so
                    // gaps in the word stream do not break consecutiveness.
                    if (i_deser_valid) begin
                        if (!is_match) begin
                            cnt_d = '0;
                        end else if ((cnt_q == 3'd0) || (is_b != pol_q)) begin
                            // First match, or alignment changed: restart run.
                            cnt_d = 3'd1;
                            pol_d = is_b;
                        end else if (cnt_q < REQ_CNT) begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                    // Detection takes priority over the timer terminal count.
                    if (i_deser_valid && is_match && (cnt_d == REQ_CNT)) begin
                        state_d     = ST_DETECTED;
                        samp_done_d = 1'b1;
                    end else if (timer_q == TIMER_LAST) begin
                        state_d = ST_TIMEOUT;
                    end
                end
            end

            default: begin
                // DETECTED / TIMEOUT: result held, count frozen until req drops.
                if (!i_start_detect_req) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                    cnt_d   = '0;
                    pol_d   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            cnt_q       <= '0;
            pol_q       <= 1'b0;
            samp_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cnt_q       <= cnt_d;
            pol_q       <= pol_d;
            samp_done_q <= samp_done_d;
        end
    end

    assign o_rx_sb_pattern_samp_done = samp_done_q;
    assign o_pattern_detected        = (state_q == ST_DETECTED);
    assign o_detect_time_out         = (state_q == ST_TIMEOUT);
    assign o_match_cnt               = cnt_q;

endmodule

// File: tb/tb_sb_rx_pattern_detector.sv
// tb/tb_sb_rx_pattern_detector.sv - scoreboard bench for sb_rx_pattern_detector
module tb_sb_rx_pattern_detector;

    localparam logic [63:0] PAT   = {32{2'b10}};
    localparam int          REQ   = 2;
    localparam int          TOTAL = 800;

    typedef struct {
        int kind;       // 0: detection pulse, 1: timeout rise
        int edge_n;     // clock edge count at which the output must appear
    } ev_t;

    typedef struct {
        logic        v;
        logic [63:0] d;
    } wd_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        req   = 1'b0;
    logic        valid = 1'b0;
    logic [63:0] data  = '0;
    logic        samp_done;
    logic        detected;
    logic        time_out;
    logic [2:0]  match_cnt;

    int  n_chk  = 0;
    int  n_fail = 0;
    int  cyc    = 0;
    ev_t exp_q[$];
    int  hist[$];       // class of every valid word this window: 0=A 1=B 2=other
    wd_t script[$];

    sb_rx_pattern_detector dut (
        .i_clk                     (clk),
        .i_rst_n                   (rst_n),
        .i_start_detect_req        (req),
        .i_deser_data              (data),
        .i_deser_valid             (valid),
        .o_rx_sb_pattern_samp_done (samp_done),
        .o_pattern_detected        (detected),
        .o_detect_time_out         (time_out),
        .o_match_cnt               (match_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    ev_t  mon_e;
    logic to_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            to_prev = 1'b0;
        end else begin
            if (samp_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected samp_done", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("samp_done event kind", 0, mon_e.kind);
                    chk("samp_done edge", cyc, mon_e.edge_n);
                    chk("detected with pulse", detected, 1);
                    chk("no timeout with pulse", time_out, 0);
                end
            end
            if (time_out && !to_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected timeout", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("timeout event kind", 1, mon_e.kind);
                    chk("timeout edge", cyc, mon_e.edge_n);
                    chk("no detected at timeout", detected, 0);
                end
            end
            to_prev = time_out;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Length of the run of identical-class pattern words ending the history.
    function automatic int trail();
        int n;
        if (hist.size() == 0 || hist[$] == 2) return 0;
        n = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] == hist[$]) n++;
            else break;
        end
        return (n < REQ) ? n : REQ;
    endfunction

    function automatic logic [63:0] rand_mis();
        logic [63:0] v;
        if ($urandom_range(0, 1) == 0) v = PAT ^ (64'd1 << $urandom_range(0, 63));
        else v = {$urandom, $urandom};
        if (v == PAT || v == ~PAT) v = 64'h1;
        return v;
    endfunction

    function automatic wd_t rand_word();
        wd_t w;
        int  r;
        r = $urandom_range(0, 9);
        w.v = 1'b1;
        if (r <= 2)      w.d = PAT;
        else if (r <= 5) w.d = ~PAT;
        else if (r <= 7) w.d = rand_mis();
        else begin
            w.v = 1'b0;
            w.d = ($urandom_range(0, 1) == 0) ? PAT : ~PAT;
        end
        return w;
    endfunction

    // mode 0: random words; 1: script then idle filler; 2: mismatches only.
    task automatic episode(input int mode, input int drop_at, input bit rst_on_det);
        wd_t w;
        ev_t e;
        int  k;
        int  cls;
        bit  det;
        bit  done;
        int  last_cnt;
        hist.delete();
        req = 1'b1; valid = 1'b0;
        step();
        chk("match_cnt at entry", match_cnt, 0);
        chk("outputs at entry", {samp_done, detected, time_out}, 0);
        done = 0; det = 0; k = 0; last_cnt = 0;
        while (!done) begin
            if (k == drop_at) begin
                req = 1'b0; valid = 1'b0;
                step();
                chk("outputs after drop", {samp_done, detected, time_out, match_cnt}, 0);
                step();
                chk("events drained after drop", exp_q.size(), 0);
                exp_q.delete();
                return;
            end
            if (mode == 1 && script.size() > 0) w = script.pop_front();
            else if (mode == 0) w = rand_word();
            else if (mode == 2) begin w.v = 1'b1; w.d = rand_mis(); end
            else begin w.v = 1'b0; w.d = PAT; end
            valid = w.v; data = w.d;
            cls = 2;
            if (w.v) begin
                cls = (w.d == PAT) ? 0 : ((w.d == ~PAT) ? 1 : 2);
                hist.push_back(cls);
            end
            det = w.v && (cls != 2) && (trail() == REQ);
            if (det) begin
                if (!rst_on_det) begin e.kind = 0; e.edge_n = cyc + 1; exp_q.push_back(e); end
            end else if (k == TOTAL - 1) begin
                e.kind = 1; e.edge_n = cyc + 1; exp_q.push_back(e);
            end
            step();
            if (det && rst_on_det) begin
                chk("samp_done before reset", samp_done, 1);
                rst_n = 1'b0;
                #1;
                chk("outputs in reset", {samp_done, detected, time_out, match_cnt}, 0);
                req = 1'b0; valid = 1'b0;
                step();
                rst_n = 1'b1;
                step();
                chk("outputs after reset release", {samp_done, detected, time_out, match_cnt}, 0);
                return;
            end
            last_cnt = trail();
            chk("match_cnt", match_cnt, last_cnt);
            if (det || k == TOTAL - 1) done = 1;
            k++;
        end
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1;
            data = ($urandom_range(0, 1) == 0) ? PAT : ~PAT;
            step();
            chk("detected level held", detected, det);
            chk("timeout level held", time_out, !det);
            chk("match_cnt frozen", match_cnt, last_cnt);
        end
        req = 1'b0; valid = 1'b0;
        step();
        chk("outputs cleared after req drop", {samp_done, detected, time_out, match_cnt}, 0);
        chk("events drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic push_word(input logic v, input logic [63:0] d);
        wd_t w;
        w.v = v; w.d = d;
        script.push_back(w);
    endtask

    initial begin
        step();
        step();
        chk("reset outputs", {samp_done, detected, time_out, match_cnt}, 0);
        rst_n = 1'b1;
        step();
        chk("idle outputs", {samp_done, detected, time_out, match_cnt}, 0);

        // Two consecutive nominal words.
        push_word(1'b1, PAT); push_word(1'b1, PAT);
        episode(1, -1, 1'b0);

        // A, mismatch, A, B, B: count 1,0,1,1,2.
        push_word(1'b1, PAT); push_word(1'b1, 64'h1); push_word(1'b1, PAT);
        push_word(1'b1, ~PAT); push_word(1'b1, ~PAT);
        episode(1, -1, 1'b0);

        // Valid gaps do not break the run.
        push_word(1'b1, PAT);
        for (int i = 0; i < 3; i++) push_word(1'b0, 64'h0);
        push_word(1'b1, PAT);
        episode(1, -1, 1'b0);

        // Timeout, then a fresh window after re-request.
        episode(2, -1, 1'b0);
        episode(2, -1, 1'b0);

        // Second matching word lands on the last timer value.
        for (int i = 0; i < TOTAL - 2; i++) push_word(1'b1, rand_mis());
        push_word(1'b1, PAT); push_word(1'b1, PAT);
        episode(1, -1, 1'b0);

        // Request withdrawn mid-window.
        episode(2, 400, 1'b0);

        // Reset hits while samp_done is high, then normal detection.
        push_word(1'b1, PAT); push_word(1'b1, PAT);
        episode(1, -1, 1'b1);
        push_word(1'b1, PAT); push_word(1'b1, PAT);
        episode(1, -1, 1'b0);

        // Randomized windows, some abandoned early.
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 3) == 0) episode(0, $urandom_range(0, 6), 1'b0);
            else episode(0, -1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
